instruction_buffer: RTL and testbench
=====================================

INSTRUCTION_BUFFER -- requirements
Module: instruction_buffer

Interface
- REQ-001 The module SHALL use one clock and an asynchronous, active-high reset, with the ports named clock and reset as elsewhere in the codebase.
- REQ-002 The module SHALL have these parameters:
  - N: default `N; superscalar width.
  - IB_SZ: default 16; number of entries, which SHALL be at least N.
- REQ-003 The module SHALL have these ports:
  - clock, input, 1: system clock.
  - reset, input, 1: asynchronous active-high reset.
  - fetch_packets, input, FETCH_PACKET: up to N packets from fetch, slot 0 oldest.
  - fetch_count, input, `NUM_SCALAR_BITS: number of valid fetch slots, 0..N.
  - ib_spots, output, `NUM_SCALAR_BITS: number of packets fetch may send this cycle.
  - flush, input, 1: mispredict restore, driven by the same signal as Dispatch restore_valid.
  - instruction_packets, output, FETCH_PACKET: N oldest entries, slot 0 at head.
  - instructions_valid, output, `NUM_SCALAR_BITS: number of valid slots in instruction_packets.
  - num_dispatched, input, `NUM_SCALAR_BITS: number of entries Dispatch consumed this cycle.
- REQ-004 When IB_STATS_EN is defined, the module SHALL also have:
  - full_stall_cycles, output, 32: stall counter (see REQ-018).
  - empty_cycles, output, 32: empty counter (see REQ-018).

Function
- REQ-005 The storage SHALL be a circular FIFO of IB_SZ entries with registered state head, tail and count (0..IB_SZ).
- REQ-006 Head and tail SHALL wrap explicitly modulo IB_SZ; IB_SZ SHALL NOT be required to be a power of two.
- REQ-007 ib_spots SHALL equal min(IB_SZ - count, N), combinational from registered state only.
- REQ-008 Enqueue: accepted = min(fetch_count, ib_spots). Slots 0..accepted-1 SHALL be written at tail..tail+accepted-1 in order. Excess slots SHALL be silently dropped.
- REQ-009 instructions_valid SHALL equal min(count, N). instruction_packets[i] SHALL be the entry at (head+i) mod IB_SZ for i < instructions_valid, and '0 otherwise. Both outputs SHALL be purely registered-state driven.
- REQ-010 Dequeue: removed = min(num_dispatched, instructions_valid). Head SHALL advance by removed.
- REQ-011 Write-to-visible latency SHALL be one cycle: a packet enqueued at edge k SHALL appear on the outputs after edge k.
- REQ-012 Same-cycle enqueue and dequeue: next count = count - removed + accepted. Space freed by a dequeue SHALL NOT be reusable in the same cycle.
- REQ-013 Full (count = IB_SZ): ib_spots = 0 and no writes occur. Empty (count = 0): instructions_valid = 0, and num_dispatched SHALL be ignored.
- REQ-014 flush high at an edge SHALL set head = tail = count = 0 and SHALL discard that cycle's enqueue and dequeue.
- REQ-015 During the flush cycle, outputs SHALL still reflect the pre-flush contents.
- REQ-016 No entry SHALL be overwritten before it is dequeued or flushed.

Reset
- REQ-017 Asynchronous reset SHALL clear head, tail, count and all entries. Outputs SHALL then be: instruction_packets = '0, instructions_valid = 0, ib_spots = min(IB_SZ, N), and stats counters = 0. Reset asserted mid-operation SHALL discard all contents immediately, without waiting for an edge.

Configuration
- REQ-018 Macro IB_STATS_EN: when defined, the stats outputs SHALL be present and behave as follows:
  - full_stall_cycles SHALL increment each cycle with fetch_count > ib_spots.
  - empty_cycles SHALL increment each cycle with count = 0.
  - Both counters SHALL wrap at 2^32, SHALL be unaffected by flush, and SHALL be cleared only by reset.
- REQ-019 When IB_STATS_EN is undefined, the stats ports and counters SHALL be absent. All other behaviour SHALL be identical.

Verification (N=3, IB_SZ=8)
- REQ-020 Reset, then fetch_count=3 with PCs 0x0, 0x4, 0x8, num_dispatched=0: next cycle instructions_valid=3, slot0 PC=0x0, slot2 PC=0x8, ib_spots=3.
- REQ-021 Fill to count=7 and offer fetch_count=3: ib_spots=1 and exactly one packet is accepted. Next cycle count=8 and ib_spots=0; with IB_STATS_EN, full_stall_cycles increments.
- REQ-022 At count=8 with head=6, apply num_dispatched=3 and fetch_count=3 together: removed=3, accepted=0, count=5, and the new head slot0 is the entry at index 1 (wrap-around).
- REQ-023 At count=5, raise flush with fetch_count=3 and num_dispatched=2: next cycle count=0, instructions_valid=0 and ib_spots=3. No flushed or newly offered packet reappears.
- REQ-024 At count=2, apply num_dispatched=3: removed=2 and count=0. Then assert reset mid-cycle with the buffer holding 4 entries: outputs clear without a clock edge.

Source files
------------

// File: rtl/instruction_buffer.sv
// Circular instruction FIFO between fetch and dispatch, N packets in and out per cycle.
// Optional IB_STATS_EN adds free-running full-stall and empty-cycle counters.

`ifndef N
`define N 3
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS $clog2(`N + 1)
`endif
`ifndef FETCH_PACKET_BITS
`define FETCH_PACKET_BITS 64
`endif

module instruction_buffer #(
    parameter int N     = `N,
    parameter int IB_SZ = 16
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [N-1:0][`FETCH_PACKET_BITS-1:0]      fetch_packets,
    input  logic [`NUM_SCALAR_BITS-1:0]               fetch_count,
    output logic [`NUM_SCALAR_BITS-1:0]               ib_spots,
    input  logic                                      flush,
    output logic [N-1:0][`FETCH_PACKET_BITS-1:0]      instruction_packets,
    output logic [`NUM_SCALAR_BITS-1:0]               instructions_valid,
    input  logic [`NUM_SCALAR_BITS-1:0]               num_dispatched
`ifdef IB_STATS_EN
    ,
    output logic [31:0]                               full_stall_cycles,
    output logic [31:0]                               empty_cycles
`endif
);

    // Handshake: fetch may send at most ib_spots packets and dispatch may take at most
    // instructions_valid; any surplus on either side is silently ignored. Both limits
    // come from registered state only, so neither side sees a combinational loop.
    localparam int SB = `NUM_SCALAR_BITS;
    localparam int PW = `FETCH_PACKET_BITS;
    localparam int CW = $clog2(IB_SZ + 1);
    localparam int IW = (IB_SZ > 1) ? $clog2(IB_SZ) : 1;
    localparam int unsigned DEPTH = IB_SZ;

    logic [PW-1:0] mem [IB_SZ];
    logic [IW-1:0] head_q;
    logic [IW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic [CW-1:0] free;
    logic [SB-1:0] spots;
    logic [SB-1:0] valid;
    logic [SB-1:0] accepted;
    logic [SB-1:0] removed;

    // Offsets never exceed IB_SZ, so a single conditional subtract wraps any depth.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= DEPTH) begin
            sum = sum - DEPTH;
        end
        return IW'(sum);
    endfunction

    always_comb begin
        free     = CW'(IB_SZ) - count_q;
        spots    = (free < CW'(N)) ? SB'(free) : SB'(N);
        valid    = (count_q < CW'(N)) ? SB'(count_q) : SB'(N);
        accepted = (fetch_count < spots) ? fetch_count : spots;
        removed  = (num_dispatched < valid) ? num_dispatched : valid;
    end

    assign ib_spots           = spots;
    assign instructions_valid = valid;

    always_comb begin
        instruction_packets = '0;
        for (int i = 0; i < N; i++) begin
            if (SB'(i) < valid) begin
                instruction_packets[i] = mem[wrap_add(head_q, i)];
            end
        end
    end

    // Writes use pre-dequeue space only, so freed slots become usable next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < IB_SZ; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (SB'(i) < accepted) begin
                    mem[wrap_add(tail_q, i)] <= fetch_packets[i];
                end
            end
            head_q  <= wrap_add(head_q, 32'(removed));
            tail_q  <= wrap_add(tail_q, 32'(accepted));
            count_q <= count_q - CW'(removed) + CW'(accepted);
        end
    end

`ifdef IB_STATS_EN
    // Counters ignore flush so they measure the whole run since reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_stall_cycles <= '0;
            empty_cycles      <= '0;
        end else begin
            if (fetch_count > spots) begin
                full_stall_cycles <= full_stall_cycles + 32'd1;
            end
            if (count_q == '0) begin
                empty_cycles <= empty_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_buffer.sv
// Directed bench for instruction_buffer (N=3, IB_SZ=8) with a dispatch-stream scoreboard.
// Point checks cover occupancy/flow-control outputs; the monitor checks every dispatched packet.

module tb_instruction_buffer;

    logic             clock;
    logic             reset;
    logic [2:0][63:0] fetch_packets;
    logic [1:0]       fetch_count;
    logic [1:0]       ib_spots;
    logic             flush;
    logic [2:0][63:0] instruction_packets;
    logic [1:0]       instructions_valid;
    logic [1:0]       num_dispatched;
`ifdef IB_STATS_EN
    logic [31:0]      full_stall_cycles;
    logic [31:0]      empty_cycles;
`endif

    int total = 0;
    int bad   = 0;

    logic [63:0] mq[$];
    logic [63:0] exp_q[$];
    int          expn_q[$];
    logic [31:0] next_pc = 32'h0;
    int          stall_m = 0;
    int          empty_m = 0;

    instruction_buffer #(.N(3), .IB_SZ(8)) dut (
        .clock               (clock),
        .reset               (reset),
        .fetch_packets       (fetch_packets),
        .fetch_count         (fetch_count),
        .ib_spots            (ib_spots),
        .flush               (flush),
        .instruction_packets (instruction_packets),
        .instructions_valid  (instructions_valid),
        .num_dispatched      (num_dispatched)
`ifdef IB_STATS_EN
        ,
        .full_stall_cycles   (full_stall_cycles),
        .empty_cycles        (empty_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] pkt(input logic [31:0] pc);
        return {pc, pc ^ 32'hDEAD_BEEF};
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, want);
        end
    endtask

    // Drive one cycle's inputs; sequential PCs are consumed even for dropped slots.
    task automatic offer(input int fc, input int nd, input bit fl);
        fetch_packets = '0;
        for (int i = 0; i < fc; i++) begin
            fetch_packets[i] = pkt(next_pc);
            next_pc = next_pc + 32'd4;
        end
        fetch_count    = 2'(fc);
        num_dispatched = 2'(nd);
        flush          = fl;
    endtask

    // Advance the reference model by one edge, push expected dispatches, then clock.
    task automatic tick();
        int sz, spots, valid, acc, rem;
        sz    = mq.size();
        spots = min2(8 - sz, 3);
        valid = min2(sz, 3);
        acc   = min2(int'(fetch_count), spots);
        rem   = min2(int'(num_dispatched), valid);
        if (int'(fetch_count) > spots) stall_m++;
        if (sz == 0) empty_m++;
        if (flush) begin
            mq.delete();
        end else begin
            if (num_dispatched != 0) begin
                for (int i = 0; i < rem; i++) exp_q.push_back(mq.pop_front());
                expn_q.push_back(rem);
            end
            for (int i = 0; i < acc; i++) mq.push_back(fetch_packets[i]);
        end
        @(posedge clock);
        #1;
        fetch_packets  = '0;
        fetch_count    = '0;
        num_dispatched = '0;
        flush          = 1'b0;
    endtask

    // Monitor: whenever dispatch consumes packets, compare them against the expected stream.
    always @(negedge clock) begin : monitor
        int got_n, want_n;
        if (!reset && !flush && num_dispatched != 0) begin
            got_n = min2(int'(num_dispatched), int'(instructions_valid));
            if (expn_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_count: got=%0d expected=<none queued>", got_n);
                want_n = 0;
            end else begin
                want_n = expn_q.pop_front();
                check("sb_count", 64'(got_n), 64'(want_n));
            end
            for (int i = 0; i < want_n; i++) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_packet: got=%h expected=<none queued>", instruction_packets[i]);
                end else begin
                    check("sb_packet", instruction_packets[i], exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        fetch_packets  = '0;
        fetch_count    = '0;
        num_dispatched = '0;
        flush          = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        check("rst_valid", 64'(instructions_valid), 64'd0);
        check("rst_spots", 64'(ib_spots), 64'd3);
        for (int i = 0; i < 3; i++) check("rst_packet", instruction_packets[i], 64'd0);

        // First packet group visible one edge later.
        offer(3, 0, 0); tick();
        check("first_valid", 64'(instructions_valid), 64'd3);
        check("first_slot0", 64'(instruction_packets[0][63:32]), 64'h0);
        check("first_slot2", 64'(instruction_packets[2][63:32]), 64'h8);
        check("first_spots", 64'(ib_spots), 64'd3);

        // Fill to 7, then offer 3 with room for only 1.
        offer(3, 0, 0); tick();
        offer(1, 0, 0); tick();
        check("seven_spots", 64'(ib_spots), 64'd1);
        offer(3, 0, 0); tick();
        check("full_spots", 64'(ib_spots), 64'd0);
        check("full_valid", 64'(instructions_valid), 64'd3);
`ifdef IB_STATS_EN
        check("full_stall", 64'(full_stall_cycles), 64'd1);
`endif

        // Walk head to 6 with the buffer full again.
        offer(0, 3, 0); tick();
        offer(3, 3, 0); tick();
        offer(3, 0, 0); tick();
        check("head6_spots", 64'(ib_spots), 64'd0);
        check("head6_slot0", 64'(instruction_packets[0][63:32]), 64'h18);

        // Dequeue while full: nothing accepted, head wraps to index 1.
        offer(3, 3, 0); tick();
        check("wrap_valid", 64'(instructions_valid), 64'd3);
        check("wrap_spots", 64'(ib_spots), 64'd3);
        check("wrap_slot0", 64'(instruction_packets[0][63:32]), 64'h2C);
        check("wrap_slot1", 64'(instruction_packets[1][63:32]), 64'h30);
        check("wrap_slot2", 64'(instruction_packets[2][63:32]), 64'h34);

        // Flush with enqueue and dequeue offered; outputs hold until the edge.
        offer(3, 2, 1);
        #1;
        check("flush_pre_valid", 64'(instructions_valid), 64'd3);
        check("flush_pre_slot0", 64'(instruction_packets[0][63:32]), 64'h2C);
        tick();
        check("flush_valid", 64'(instructions_valid), 64'd0);
        check("flush_spots", 64'(ib_spots), 64'd3);
        check("flush_slot0", instruction_packets[0], 64'd0);

        // Over-dispatch: only the two present entries are removed.
        offer(2, 0, 0); tick();
        offer(0, 3, 0); tick();
        check("drain_valid", 64'(instructions_valid), 64'd0);
        check("drain_spots", 64'(ib_spots), 64'd3);

        // Hold 4 entries, then reset between edges.
        offer(3, 0, 0); tick();
        offer(1, 0, 0); tick();
        check("four_valid", 64'(instructions_valid), 64'd3);
        check("four_slot0", 64'(instruction_packets[0][63:32]), 64'h60);
        check("four_spots", 64'(ib_spots), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", 64'(instructions_valid), 64'd0);
        check("async_spots", 64'(ib_spots), 64'd3);
        check("async_slot0", instruction_packets[0], 64'd0);
`ifdef IB_STATS_EN
        check("async_stall", 64'(full_stall_cycles), 64'd0);
        check("async_empty", 64'(empty_cycles), 64'd0);
`endif
        #2;
        reset = 1'b0;
        mq.delete();
        stall_m = 0;
        empty_m = 0;

        // Post-reset traffic: only new packets appear.
        offer(3, 0, 0); tick();
        check("post_slot0", 64'(instruction_packets[0][63:32]), 64'h70);
        offer(0, 3, 0); tick();
        check("post_valid", 64'(instructions_valid), 64'd0);
        offer(0, 0, 0); tick();
        offer(0, 0, 0); tick();
`ifdef IB_STATS_EN
        check("end_stall", 64'(full_stall_cycles), 64'(stall_m));
        check("end_empty", 64'(empty_cycles), 64'(empty_m));
`endif
        check("sb_leftover", 64'(exp_q.size()), 64'd0);
        check("sb_leftover_n", 64'(expn_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
